// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, streams words from instruction memory into a
// show-ahead prefetch FIFO and hands {pc, instr} pairs to decode; redirects flush the queue.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [31:0]                   imem_addr,
  input  logic [31:0]                   imem_instr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [31:0]                   out_pc,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   pc;
  logic [31:0]   redir_aligned;
  logic          push, pop;

  assign redir_aligned = redirect_pc & ~32'h3;
  assign imem_addr     = pc;

  // A redirect in flight hides the head so decode never consumes a stale word.
  assign out_valid = (fifo_count != '0) & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect_valid & ((fifo_count < DEPTH_C) | pop);

  assign out_pc    = fifo_q[rd_ptr].pc;
  assign out_instr = fifo_q[rd_ptr].instr;

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr] <= '{pc: pc, instr: imem_instr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect_valid) begin
      pc         <= redir_aligned;
      rd_ptr     <= wr_ptr;
      fifo_count <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure, full FIFO,
// redirects (single, back-to-back, PC wrap) and reset overriding redirect.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_instr;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Memory model: word at address a holds a ^ 32'hA5A5_0000.
  assign imem_instr = imem_addr ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_pc"}, out_pc, exp_pc);
    chk({tag, "_instr"}, out_instr, exp_pc ^ 32'hA5A5_0000);
  endtask

  initial begin
    int n;
    logic [31:0] wrap_seq [4];
    wrap_seq[0] = 32'hFFFF_FFF8; wrap_seq[1] = 32'hFFFF_FFFC;
    wrap_seq[2] = 32'h0;         wrap_seq[3] = 32'h4;

    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();

    // 1: reset state then free-running stream
    rst = 1'b0; out_ready = 1'b1; #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_head("t1", 32'(4 * (k - 1)));
    end

    // 2: backpressure fills FIFO and stalls PC at 0x10
    rst = 1'b1; out_ready = 1'b0; tick(); rst = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      n = (j < 4) ? j : 4;
      chk("t2_count", {29'd0, fifo_count}, 32'(n));
      chk("t2_addr", imem_addr, 32'(4 * n));
    end

    // 3: full with pop pushes in the same cycle
    out_ready = 1'b1; #1;
    chk_head("t3_first", 32'h0);
    tick();
    chk("t3_count", {29'd0, fifo_count}, 32'd4);
    chk("t3_addr", imem_addr, 32'h14);
    for (int k = 1; k <= 4; k++) begin
      chk_head("t3_seq", 32'(4 * k));
      tick();
    end

    // 4: redirect to 0x203 with three entries queued
    rst = 1'b1; out_ready = 1'b0; tick(); rst = 1'b0;
    tick(); tick(); tick();
    chk("t4_count3", {29'd0, fifo_count}, 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h203; out_ready = 1'b1; #1;
    chk("t4_redir_valid", {31'd0, out_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("t4_count0", {29'd0, fifo_count}, 32'd0);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_n1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_head("t4_new", 32'h200);
    tick();
    chk_head("t4_next", 32'h204);

    // 5: back-to-back redirects, last one wins
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("t5_a_valid", {31'd0, out_valid}, 32'd0);
    tick();
    redirect_pc = 32'h300; #1;
    chk("t5_b_addr", imem_addr, 32'h100);
    chk("t5_b_valid", {31'd0, out_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("t5_c_addr", imem_addr, 32'h300);
    chk("t5_c_count", {29'd0, fifo_count}, 32'd0);
    tick();
    chk_head("t5_first", 32'h300);
    tick();
    chk_head("t5_second", 32'h304);

    // 6: PC wraps past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; tick();
    redirect_valid = 1'b0; tick();
    for (int k = 0; k < 4; k++) begin
      chk_head("t6_wrap", wrap_seq[k]);
      tick();
    end

    // 7: reset beats a simultaneous redirect
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500; tick();
    rst = 1'b0; redirect_valid = 1'b0; #1;
    chk("t7_count", {29'd0, fifo_count}, 32'd0);
    chk("t7_valid", {31'd0, out_valid}, 32'd0);
    chk("t7_addr", imem_addr, 32'h0);
    tick();
    chk_head("t7_after", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
